// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one 32-bit ALU (add / xor / sub / unsigned slt, with C/Z/V/N flags)
// among N_REQ requesters. Grants rotate round-robin. Each granted operation is
// computed combinationally and captured in a single output register. That
// register is drained through a valid/ready response port, and each result is
// tagged with the index of the requester that produced it.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-high reset
//   req_valid      [N_REQ]    requester i presents an operation
//   req_ready      [N_REQ]    one-hot (or zero): requester i accepted this cycle
//   req_a, req_b   [32*N_REQ] operands, requester i at bits [32i+31:32i]
//   req_ctrl       [2*N_REQ]  op, requester i at bits [2i+1:2i]
//                             (00 add, 01 xor, 10 sub, 11 slt)
//   resp_valid     output register holds a result
//   resp_ready     consumer takes the result this cycle
//   resp_id        [ID_W] index of the requester that produced the result
//   resp_result    [32] ALU result
//   resp_carry/zero/overflow/negative   ALU flags
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_a,
  input  logic [32*N_REQ-1:0]  req_b,
  input  logic [2*N_REQ-1:0]   req_ctrl,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [31:0]          resp_result,
  output logic                 resp_carry,
  output logic                 resp_zero,
  output logic                 resp_overflow,
  output logic                 resp_negative
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_XOR = 2'b01,
    OP_SUB = 2'b10,
    OP_SLT = 2'b11
  } alu_op_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q;
  logic [31:0]     result_q;
  logic            carry_q, zero_q, overflow_q, negative_q;

  logic            can_accept;
  logic            any_valid;
  logic            grant;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] scan_idx;

  logic [31:0]     op_a, op_b;
  logic [1:0]      op_ctrl;
  logic [32:0]     sum33, diff33;
  logic [31:0]     alu_res;
  logic            alu_c, alu_z, alu_v, alu_n;

  // A held result that is being drained this cycle frees the slot immediately.
  assign can_accept = (state_q == S_EMPTY) || resp_ready;

  // -------------------------------------------------------------------------
  // Round-robin scan starting at ptr_q. Only req_valid and ptr_q feed it, so
  // req_ready never depends on operand or ctrl values.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    any_valid = 1'b0;
    gnt_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // ptr_q + k taken modulo N_REQ. The result is always below N_REQ, so
      // wrapping at ID_W bits and then subtracting N_REQ gives the correct index.
      if (int'(ptr_q) + k >= N_REQ) begin
        scan_idx = ptr_q + ID_W'(k) - ID_W'(N_REQ);
      end else begin
        scan_idx = ptr_q + ID_W'(k);
      end
      if (!any_valid && req_valid[scan_idx]) begin
        any_valid = 1'b1;
        gnt_id    = scan_idx;
      end
    end
  end

  assign grant = any_valid && can_accept && !rst;

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant && (gnt_id == ID_W'(k))) begin
        req_ready[k] = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Operand mux feeding the single shared ALU
  // -------------------------------------------------------------------------
  always_comb begin
    op_a    = '0;
    op_b    = '0;
    op_ctrl = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_id == ID_W'(k)) begin
        op_a    = req_a[32*k +: 32];
        op_b    = req_b[32*k +: 32];
        op_ctrl = req_ctrl[2*k +: 2];
      end
    end
  end

  // Subtraction is A + ~B + 1, so the carry out is 1 exactly when there is no borrow.
  assign sum33  = {1'b0, op_a} + {1'b0, op_b};
  assign diff33 = {1'b0, op_a} + {1'b0, ~op_b} + 33'd1;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_z   = 1'b0;
    alu_v   = 1'b0;
    alu_n   = 1'b0;
    unique case (alu_op_e'(op_ctrl))
      OP_ADD: begin
        alu_res = sum33[31:0];
        alu_c   = sum33[32];
        alu_v   = (op_a[31] == op_b[31]) && (alu_res[31] != op_a[31]);
        alu_z   = (alu_res == 32'd0);
        alu_n   = alu_res[31];
      end
      OP_SUB: begin
        alu_res = diff33[31:0];
        alu_c   = diff33[32];
        alu_v   = (op_a[31] != op_b[31]) && (alu_res[31] != op_a[31]);
        alu_z   = (alu_res == 32'd0);
        alu_n   = alu_res[31];
      end
      OP_XOR: begin
        alu_res = op_a ^ op_b;
      end
      OP_SLT: begin
        alu_res = {31'd0, ~diff33[32]};
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM next state and pointer update
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (grant) begin
      state_d = S_FULL;
      ptr_d   = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end else if (state_q == S_FULL && resp_ready) begin
      state_d = S_EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples values from before the edge regardless of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result register is reset as well as the control state,
      // because resp_id/result/flags are visible outputs right after reset.
      state_q    <= S_EMPTY;
      ptr_q      <= '0;
      id_q       <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      if (grant) begin
        id_q       <= gnt_id;
        result_q   <= alu_res;
        carry_q    <= alu_c;
        zero_q     <= alu_z;
        overflow_q <= alu_v;
        negative_q <= alu_n;
      end
    end
  end

  assign resp_valid    = (state_q == S_FULL);
  assign resp_id       = id_q;
  assign resp_result   = result_q;
  assign resp_carry    = carry_q;
  assign resp_zero     = zero_q;
  assign resp_overflow = overflow_q;
  assign resp_negative = negative_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// Directed bench for alu_share_arbiter (N_REQ = 4). Inputs change 1 time unit
// after each rising edge. All outputs are sampled at that point or later,
// never on the edge itself. Flags are compared packed as {C, Z, V, N}.
// ---------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [2*N-1:0]    req_ctrl;
  logic              resp_valid;
  logic              resp_ready;
  logic [ID_W-1:0]   resp_id;
  logic [31:0]       resp_result;
  logic              resp_carry, resp_zero, resp_overflow, resp_negative;

  int tests_run = 0;
  int tests_failed = 0;

  alu_share_arbiter #(.N_REQ(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_ctrl      (req_ctrl),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_result   (resp_result),
    .resp_carry    (resp_carry),
    .resp_zero     (resp_zero),
    .resp_overflow (resp_overflow),
    .resp_negative (resp_negative)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_resp(input string tag, input logic v, input logic [ID_W-1:0] id,
                            input logic [31:0] res, input logic [3:0] flags);
    check({tag, ".valid"},  {31'd0, resp_valid}, {31'd0, v});
    check({tag, ".id"},     {30'd0, resp_id}, {30'd0, id});
    check({tag, ".result"}, resp_result, res);
    check({tag, ".flags"},
          {28'd0, resp_carry, resp_zero, resp_overflow, resp_negative},
          {28'd0, flags});
  endtask

  task automatic check_ready(input string tag, input logic [N-1:0] exp);
    check(tag, {28'd0, req_ready}, {28'd0, exp});
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c);
    req_a[32*i +: 32]  = a;
    req_b[32*i +: 32]  = b;
    req_ctrl[2*i +: 2] = c;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_ctrl   = '0;
    resp_ready = 1'b0;

    // ---- reset: two cycles ----
    tick();
    check_resp("reset", 1'b0, 2'd0, 32'h0, 4'b0000);
    check_ready("reset.ready", 4'b0000);
    tick();
    rst = 1'b0;

    // ---- single add on req 2: 7FFFFFFF + 1 ----
    set_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 2'b00);
    req_valid = 4'b0100;
    #1;
    check_ready("add.ready", 4'b0100);
    tick();
    check_resp("add.resp", 1'b1, 2'd2, 32'h8000_0000, 4'b0011);
    check_ready("add.full_no_ready", 4'b0000);
    req_valid  = 4'b0000;
    resp_ready = 1'b1;
    tick();
    check("add.drained", {31'd0, resp_valid}, 32'd0);

    // ---- reset again so the round-robin pass starts at ptr 0 ----
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // ---- round robin, all four valid, resp_ready held high ----
    set_op(0, 32'd10,       32'd20,       2'b00); // 30, flags 0
    set_op(1, 32'd5,        32'd5,        2'b10); // 0, Z=1 C=1
    set_op(2, 32'd3,        32'd5,        2'b10); // FFFFFFFE, borrow, N=1
    set_op(3, 32'd3,        32'd7,        2'b11); // slt -> 1, flags 0
    req_valid = 4'b1111;
    #1;
    check_ready("rr.g0", 4'b0001);
    tick();
    check_resp("rr.r0", 1'b1, 2'd0, 32'd30, 4'b0000);
    check_ready("rr.g1", 4'b0010);
    tick();
    check_resp("rr.r1", 1'b1, 2'd1, 32'd0, 4'b1100);
    check_ready("rr.g2", 4'b0100);
    tick();
    check_resp("rr.r2", 1'b1, 2'd2, 32'hFFFF_FFFE, 4'b0001);
    check_ready("rr.g3", 4'b1000);
    tick();
    check_resp("rr.r3", 1'b1, 2'd3, 32'd1, 4'b0000);
    check_ready("rr.g4", 4'b0001);
    tick();
    check_resp("rr.r4", 1'b1, 2'd0, 32'd30, 4'b0000);

    // ---- backpressure: result held, req 0/1 valid, resp_ready low ----
    resp_ready = 1'b0;
    req_valid  = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ready($sformatf("bp.ready%0d", i), 4'b0000);
      tick();
      check_resp($sformatf("bp.hold%0d", i), 1'b1, 2'd0, 32'd30, 4'b0000);
    end
    resp_ready = 1'b1;
    #1;
    check_ready("bp.release", 4'b0010);
    tick();
    check_resp("bp.next", 1'b1, 2'd1, 32'd0, 4'b1100);

    // ---- pointer wrap: grant req 3, then only 0 and 3 valid ----
    req_valid = 4'b1000;
    #1;
    check_ready("wrap.g3", 4'b1000);
    tick();
    check_resp("wrap.r3", 1'b1, 2'd3, 32'd1, 4'b0000);
    req_valid = 4'b1001;
    #1;
    check_ready("wrap.g0", 4'b0001);
    tick();
    check_resp("wrap.r0", 1'b1, 2'd0, 32'd30, 4'b0000);
    check_ready("wrap.g3b", 4'b1000);
    tick();
    check_resp("wrap.r3b", 1'b1, 2'd3, 32'd1, 4'b0000);

    // ---- xor on req 1, then drain with no further requests ----
    set_op(1, 32'hFFFF_0000, 32'h0F0F_0F0F, 2'b01);
    req_valid = 4'b0010;
    #1;
    check_ready("xor.ready", 4'b0010);
    tick();
    check_resp("xor.resp", 1'b1, 2'd1, 32'hF0F0_0F0F, 4'b0000);
    req_valid = 4'b0000;
    tick();
    check_resp("xor.drained", 1'b0, 2'd1, 32'hF0F0_0F0F, 4'b0000);

    // ---- reset mid-operation ----
    resp_ready = 1'b0;
    req_valid  = 4'b0100;
    #1;
    check_ready("rstmid.g2", 4'b0100);
    tick();
    check_resp("rstmid.pending", 1'b1, 2'd2, 32'hFFFF_FFFE, 4'b0001);
    rst = 1'b1;
    #1;
    check_ready("rstmid.ready_in_rst", 4'b0000);
    tick();
    check_resp("rstmid.cleared", 1'b0, 2'd0, 32'h0, 4'b0000);
    rst       = 1'b0;
    req_valid = 4'b0101;
    #1;
    check_ready("rstmid.ptr0", 4'b0001);
    tick();
    check_resp("rstmid.r0", 1'b1, 2'd0, 32'd30, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
